// File: rtl/dram_cycle_arb_pkg.sv
// Shared constants for the DRAM cycle arbiter: cycle owner codes and phase encodings.
package dram_cycle_arb_pkg;

  typedef enum logic [1:0] {
    CYC_IDLE = 2'b00,
    CYC_VID  = 2'b01,
    CYC_CPU  = 2'b10
  } cyc_t;

  typedef enum logic [1:0] {
    PH_CBEG      = 2'd0,
    PH_POST_CBEG = 2'd1,
    PH_PRE_CEND  = 2'd2,
    PH_CEND      = 2'd3
  } ph_t;

  function automatic ph_t ph_inc(input ph_t p);
    logic [1:0] raw;
    raw = p + 2'd1;
    return ph_t'(raw);
  endfunction

endpackage

// File: rtl/dram_cycle_arb_if.sv
// Bus between the DRAM cycle arbiter (slave) and its clients / DRAM mux (master).
interface dram_cycle_arb_if #(
  parameter int AW = 21
);
  logic          cbeg;
  logic          post_cbeg;
  logic          pre_cend;
  logic          cend;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_strobe;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic          cpu_next;
  logic          cpu_strobe;
  logic [1:0]    cyc_type;
  logic [AW-1:0] dram_addr;
  logic          dram_we;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr,
    input  cbeg, post_cbeg, pre_cend, cend, vid_strobe, cpu_next, cpu_strobe,
           cyc_type, dram_addr, dram_we
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr,
    output cbeg, post_cbeg, pre_cend, cend, vid_strobe, cpu_next, cpu_strobe,
           cyc_type, dram_addr, dram_we
  );
endinterface

// File: rtl/dram_phase_gen.sv
// Free-running 4-phase counter with one-hot phase strobes; strobes are held low during reset.
module dram_phase_gen
  import dram_cycle_arb_pkg::*;
(
  input  logic clk,
  input  logic srst,
  output logic cbeg,
  output logic post_cbeg,
  output logic pre_cend,
  output logic cend
);

  ph_t        ph_reg;
  ph_t        ph_next;
  logic [3:0] strb;

  always_comb begin
    ph_next = ph_inc(ph_reg);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ph_reg <= PH_CBEG;
    end else begin
      ph_reg <= ph_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_strb
    assign strb[gi] = ~srst & (ph_reg == 2'(gi));
  end

  assign cbeg      = strb[PH_CBEG];
  assign post_cbeg = strb[PH_POST_CBEG];
  assign pre_cend  = strb[PH_PRE_CEND];
  assign cend      = strb[PH_CEND];

endmodule

// File: rtl/dram_cycle_arb.sv
// DRAM cycle arbiter: video-first allocation of each 4-fclk cycle, address mux and CPU handshake.
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module dram_cycle_arb
  import dram_cycle_arb_pkg::*;
#(
  parameter int AW          = 21,
  parameter int VID_MAX_RUN = 7
) (
  input  logic              fclk,
  input  logic              rst,
  dram_cycle_arb_if.slave   bus
);

  if (VID_MAX_RUN < 1 || VID_MAX_RUN > 15) begin : g_bad_run
    $error("VID_MAX_RUN must be in 1..15");
  end

  logic          cbeg;
  logic          post_cbeg;
  logic          pre_cend;
  logic          cend;
  logic          cpu_win;
  logic          vid_win;
  cyc_t          type_reg;
  cyc_t          type_next;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] addr_next;
  logic          we_reg;
  logic          we_next;

  dram_phase_gen u_phase (
    .clk       (fclk),
    .srst      (rst),
    .cbeg      (cbeg),
    .post_cbeg (post_cbeg),
    .pre_cend  (pre_cend),
    .cend      (cend)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] run_reg;
  logic [3:0] run_next;
  logic       starve;

  // Once video has run VID_MAX_RUN cycles past a waiting CPU, the CPU takes the next one.
  assign starve  = (run_reg == 4'(VID_MAX_RUN));
  assign cpu_win = bus.cpu_req & (~bus.vid_req | starve);

  always_comb begin
    run_next = run_reg;
    if (cend) begin
      if (cpu_win || !bus.cpu_req) begin
        run_next = 4'd0;
      end else if (vid_win) begin
        run_next = run_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      run_reg <= 4'd0;
    end else begin
      run_reg <= run_next;
    end
  end
`else
  assign cpu_win = bus.cpu_req & ~bus.vid_req;
`endif

  assign vid_win = bus.vid_req & ~cpu_win;

  // Owner is chosen in the cend fclk and takes effect from the following cbeg.
  always_comb begin
    type_next = type_reg;
    addr_next = addr_reg;
    we_next   = we_reg;
    if (cend) begin
      if (vid_win) begin
        type_next = CYC_VID;
        addr_next = bus.vid_addr;
        we_next   = 1'b0;
      end else if (cpu_win) begin
        type_next = CYC_CPU;
        addr_next = bus.cpu_addr;
        we_next   = ~bus.cpu_rnw;
      end else begin
        type_next = CYC_IDLE;
        we_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      type_reg <= CYC_IDLE;
      addr_reg <= '0;
      we_reg   <= 1'b0;
    end else begin
      type_reg <= type_next;
      addr_reg <= addr_next;
      we_reg   <= we_next;
    end
  end

  assign bus.cbeg       = cbeg;
  assign bus.post_cbeg  = post_cbeg;
  assign bus.pre_cend   = pre_cend;
  assign bus.cend       = cend;
  assign bus.cpu_next   = cend & cpu_win;
  assign bus.vid_strobe = cend & (type_reg == CYC_VID);
  assign bus.cpu_strobe = cend & (type_reg == CYC_CPU);
  assign bus.cyc_type   = type_reg;
  assign bus.dram_addr  = addr_reg;
  assign bus.dram_we    = we_reg;

endmodule

// File: tb/tb_dram_cycle_arb.sv
// Self-checking bench for dram_cycle_arb: per-cycle vector table plus hand sequences, scoreboarded.
module tb_dram_cycle_arb;
  import dram_cycle_arb_pkg::*;

  localparam int AW = 21;

  logic fclk = 1'b0;
  logic rst  = 1'b1;

  always #5 fclk = ~fclk;

  dram_cycle_arb_if #(.AW(AW)) bus ();

  dram_cycle_arb #(.AW(AW), .VID_MAX_RUN(3)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    logic          vid_req;
    logic          cpu_req;
    logic          cpu_rnw;
    logic [AW-1:0] vid_addr;
    logic [AW-1:0] cpu_addr;
    cyc_t          exp_type;
  } vec_t;

  typedef struct {
    cyc_t          typ;
    logic [AW-1:0] addr;
    logic          we;
  } exp_t;

  exp_t          exp_q[$];
  vec_t          tbl[12];
  int            n_pass   = 0;
  int            n_total  = 0;
  int            ph_exp   = 0;
  cyc_t          cur_type = CYC_IDLE;
  logic [AW-1:0] cur_addr = '0;
  logic          cur_we   = 1'b0;
  bit            rst_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One fclk: drive just after the edge, check at the falling edge.
  task automatic step(input logic r, input logic vreq, input logic creq, input logic rnw,
                      input logic [AW-1:0] vaddr, input logic [AW-1:0] caddr, input cyc_t dec);
    exp_t       e;
    logic [3:0] strb_exp;
    @(posedge fclk);
    #1;
    rst          = r;
    bus.vid_req  = vreq;
    bus.cpu_req  = creq;
    bus.cpu_rnw  = rnw;
    bus.vid_addr = vaddr;
    bus.cpu_addr = caddr;
    @(negedge fclk);
    if (r) begin
      if (rst_seen)
        chk("reset_outputs",
            64'({bus.cbeg, bus.post_cbeg, bus.pre_cend, bus.cend, bus.vid_strobe,
                 bus.cpu_strobe, bus.cpu_next, bus.dram_we, bus.cyc_type, bus.dram_addr}),
            64'(0));
      rst_seen = 1'b1;
      ph_exp   = 0;
      cur_type = CYC_IDLE;
      cur_addr = '0;
      cur_we   = 1'b0;
      exp_q.delete();
    end else begin
      rst_seen = 1'b0;
      if (ph_exp == 0 && exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        cur_type = e.typ;
        cur_addr = e.addr;
        cur_we   = e.we;
      end
      strb_exp = 4'b0001 << ph_exp;
      chk("phase_strobes", 64'({bus.cend, bus.pre_cend, bus.post_cbeg, bus.cbeg}), 64'(strb_exp));
      chk("cycle_owner", 64'({bus.cyc_type, bus.dram_we, bus.dram_addr}),
          64'({cur_type, cur_we, cur_addr}));
      chk("data_strobes", 64'({bus.vid_strobe, bus.cpu_strobe}),
          64'({ph_exp == 3 && cur_type == CYC_VID, ph_exp == 3 && cur_type == CYC_CPU}));
      chk("cpu_next", 64'(bus.cpu_next), 64'(ph_exp == 3 && dec == CYC_CPU));
      if (ph_exp == 3) begin
        e.typ  = dec;
        e.we   = (dec == CYC_CPU) && !rnw;
        e.addr = (dec == CYC_VID) ? vaddr : (dec == CYC_CPU) ? caddr : cur_addr;
        exp_q.push_back(e);
      end
      ph_exp = (ph_exp + 1) % 4;
    end
  endtask

  // One DRAM cycle (ph 0..3) with requests held level; dec is the owner expected for the next cycle.
  task automatic cyc(input logic vreq, input logic creq, input logic rnw,
                     input logic [AW-1:0] vaddr, input logic [AW-1:0] caddr, input cyc_t dec);
    for (int k = 0; k < 4; k++) step(1'b0, vreq, creq, rnw, vaddr, caddr, dec);
  endtask

  initial begin
    cyc_t exp_a;
    bus.vid_req  = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.vid_addr = '0;
    bus.cpu_addr = '0;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 21'h00000, 21'h1A2B3, CYC_CPU};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 21'h0ABCD, 21'h00000, CYC_VID};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 21'h00F00, 21'h15555, CYC_VID};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 21'h00000, 21'h15555, CYC_CPU};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 21'h1FFFF, 21'h00000, CYC_VID};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 21'h00000, 21'h00001, CYC_CPU};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h00000, CYC_IDLE};

    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, CYC_IDLE);

    foreach (tbl[i])
      cyc(tbl[i].vid_req, tbl[i].cpu_req, tbl[i].cpu_rnw, tbl[i].vid_addr, tbl[i].cpu_addr,
          tbl[i].exp_type);

    // Video and CPU both held for 64 fclk.
    for (int i = 0; i < 16; i++) begin
      exp_a = CYC_VID;
`ifdef ARB_STARVE_GUARD_EN
      if (i % 4 == 3) exp_a = CYC_CPU;
`endif
      cyc(1'b1, 1'b1, 1'b1, 21'h00123, 21'h00456, exp_a);
    end
    cyc(1'b0, 1'b0, 1'b1, '0, '0, CYC_IDLE);

    // Reset lands at ph==1 of a CPU write; its strobe must never appear.
    cyc(1'b0, 1'b1, 1'b0, '0, 21'h0BEEF, CYC_CPU);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 21'h0BEEF, CYC_IDLE);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 21'h0BEEF, CYC_IDLE);
    cyc(1'b0, 1'b1, 1'b0, '0, 21'h0BEEF, CYC_CPU);
    cyc(1'b0, 1'b0, 1'b1, '0, '0, CYC_IDLE);

    // A request pulse outside the decision phase is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 21'h00777, CYC_IDLE);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, 21'h00777, CYC_IDLE);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 21'h00777, CYC_IDLE);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 21'h00777, CYC_IDLE);
    cyc(1'b0, 1'b0, 1'b1, '0, '0, CYC_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
